// File: rtl/counter_pkg.sv
// counter_pkg: direction encodings and width helper shared by the counter slice
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // All-ones value for widths 1..32, returned in a 32-bit container
    function automatic logic [31:0] all_ones(input int w);
        return 32'hFFFF_FFFF >> (32 - w);
    endfunction

endpackage

// File: rtl/counter_if.sv
// counter_if: control and status bundle between a counter and its user
interface counter_if #(parameter int DATA_WIDTH = 4);

    logic                  en;
    logic                  direction;
    logic                  load;
    logic [DATA_WIDTH-1:0] load_value;
    logic [DATA_WIDTH-1:0] count;
    logic                  tc;
    logic                  wrap;

    modport master (output en, direction, load, load_value, input count, tc, wrap);
    modport slave  (input en, direction, load, load_value, output count, tc, wrap);

endinterface

// File: rtl/counter_next.sv
// counter_next: next-count, terminal-count and wrap detection; COUNTER_SATURATE_EN selects saturation
module counter_next
    import counter_pkg::*;
#(
    parameter int DATA_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0] count,
    input  logic                  direction,
    input  logic                  en,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_value,
    output logic [DATA_WIDTH-1:0] count_nxt,
    output logic                  tc,
    output logic                  wrap_nxt
);

    localparam logic [DATA_WIDTH-1:0] MAX = DATA_WIDTH'(all_ones(DATA_WIDTH));

    logic                  at_limit;
    logic [DATA_WIDTH-1:0] step;

    // Limit detection drives both tc and the overflow/underflow pulse
    always_comb begin
        at_limit  = (direction == DIR_UP) ? (count == MAX) : (count == '0);
        step      = (direction == DIR_UP) ? count + DATA_WIDTH'(1) : count - DATA_WIDTH'(1);
        tc        = at_limit;
        wrap_nxt  = !load && en && at_limit;
`ifdef COUNTER_SATURATE_EN
        count_nxt = load ? load_value : (en && !at_limit) ? step : count;
`else
        count_nxt = load ? load_value : en ? step : count;
`endif
    end

endmodule

// File: rtl/counter.sv
// counter: up/down counter with load, tc and wrap pulse; define COUNTER_SATURATE_EN to saturate
module counter
    import counter_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic     clk,
    input  logic     rst,
    counter_if.slave bus
);

    logic [DATA_WIDTH-1:0] count_nxt;
    logic                  wrap_nxt;

    counter_next #(.DATA_WIDTH(DATA_WIDTH)) u_next (
        .count      (bus.count),
        .direction  (bus.direction),
        .en         (bus.en),
        .load       (bus.load),
        .load_value (bus.load_value),
        .count_nxt  (count_nxt),
        .tc         (bus.tc),
        .wrap_nxt   (wrap_nxt)
    );

    // Count and wrap registers; reset overrides load and enable
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.count <= RESET_VALUE;
            bus.wrap  <= 1'b0;
        end else begin
            bus.count <= count_nxt;
            bus.wrap  <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_counter.sv
// tb_counter: randomized and directed checks of counter against a behavioural model
module tb_counter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;
    int   m_cnt  = 0;
    int   m_wrap = 0;
    bit   armed  = 1'b0;

    counter_if #(.DATA_WIDTH(4)) bus ();

    counter #(.DATA_WIDTH(4), .RESET_VALUE(4'd0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #2 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: plain modular (or clamped) arithmetic on an integer
    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0;
            m_wrap = 0;
            armed = 1'b1;
        end else if (bus.load) begin
            m_cnt = int'(bus.load_value);
            m_wrap = 0;
        end else if (bus.en) begin
            m_wrap = (bus.direction ? m_cnt == 15 : m_cnt == 0) ? 1 : 0;
`ifdef COUNTER_SATURATE_EN
            m_cnt = bus.direction ? (m_cnt < 15 ? m_cnt + 1 : 15) : (m_cnt > 0 ? m_cnt - 1 : 0);
`else
            m_cnt = (m_cnt + (bus.direction ? 1 : 15)) % 16;
`endif
        end else begin
            m_wrap = 0;
        end
    end

    // Compare every cycle once the model is anchored by a reset
    always @(negedge clk) begin
        if (armed) begin
            chk("count", 32'(bus.count), 32'(m_cnt));
            chk("wrap", 32'(bus.wrap), 32'(m_wrap));
            chk("tc", 32'(bus.tc), (bus.direction ? m_cnt == 15 : m_cnt == 0) ? 32'd1 : 32'd0);
        end
    end

    task automatic drive(input logic r, input logic e, input logic d, input logic l, input logic [3:0] lv);
        rst = r;
        bus.en = e;
        bus.direction = d;
        bus.load = l;
        bus.load_value = lv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] seq [6];
        seq = '{4'd1, 4'd2, 4'd3, 4'd2, 4'd1, 4'd0};
        bus.en = 1'b0;
        bus.direction = 1'b1;
        bus.load = 1'b0;
        bus.load_value = '0;
        repeat (25) drive(1, 0, 1, 0, 0);
        chk("reset_count", 32'(bus.count), 0);
        chk("reset_wrap", 32'(bus.wrap), 0);
        repeat (3) drive(0, 1, 1, 0, 0);
        chk("up3", 32'(bus.count), 3);
        drive(0, 0, 1, 1, 4'd15);
        chk("tc_at_15", 32'(bus.tc), 1);
        drive(0, 1, 1, 0, 0);
`ifdef COUNTER_SATURATE_EN
        chk("sat_up", 32'(bus.count), 15);
        chk("sat_up_wrap", 32'(bus.wrap), 1);
        repeat (2) drive(0, 1, 1, 0, 0);
        chk("sat_up3", 32'(bus.count), 15);
        chk("sat_up3_wrap", 32'(bus.wrap), 1);
        drive(0, 0, 0, 1, 4'd0);
        drive(0, 1, 0, 0, 0);
        chk("sat_down", 32'(bus.count), 0);
        chk("sat_down_wrap", 32'(bus.wrap), 1);
`else
        chk("up_wrap", 32'(bus.count), 0);
        chk("up_wrap_pulse", 32'(bus.wrap), 1);
        drive(0, 1, 1, 0, 0);
        chk("wrap_one_cycle", 32'(bus.wrap), 0);
        drive(0, 0, 0, 1, 4'd2);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        chk("down_zero", 32'(bus.count), 0);
        chk("tc_at_0", 32'(bus.tc), 1);
        drive(0, 1, 0, 0, 0);
        chk("down_wrap", 32'(bus.count), 15);
        chk("down_wrap_pulse", 32'(bus.wrap), 1);
`endif
        drive(0, 0, 1, 1, 4'd0);
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, i < 3, 0, 0);
            chk("toggle", 32'(bus.count), 32'(seq[i]));
        end
        drive(0, 1, 1, 1, 4'd9);
        chk("load_over_en", 32'(bus.count), 9);
        repeat (5) drive(0, 0, 1, 0, 0);
        chk("hold", 32'(bus.count), 9);
        drive(1, 1, 1, 1, 4'd7);
        chk("rst_over_load", 32'(bus.count), 0);
        repeat (2000)
            drive($urandom_range(63) == 0, $urandom_range(3) != 0, 1'($urandom),
                  $urandom_range(7) == 0, 4'($urandom));
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/counter.md
Name: counter

Overview:
- Synchronous up/down binary counter, parameterisable width, with enable, parallel load and terminal-count/wrap status.
- Generic building block used as a timebase, address generator or event counter inside larger datapaths.
- Single clock domain; all outputs registered except `tc`, which is combinational from registered state.

Parameters:
- `DATA_WIDTH`, default 4: width of the count register (legal ≥ 1).
- `RESET_VALUE`, default 0: value loaded into `count` on reset; must fit in `DATA_WIDTH` bits.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `en`  in  1  count enable; 1 = step the counter this cycle.
- `direction`  in  1  1 = count up, 0 = count down.
- `load`  in  1  parallel load strobe.
- `load_value`  in  `DATA_WIDTH`  value captured on load.
- `count`  out  `DATA_WIDTH`  current count (registered).
- `tc`  out  1  terminal count (combinational):
  - 1 when `direction`=1 and `count`=all-ones;
  - 1 when `direction`=0 and `count`=0.
- `wrap`  out  1  registered one-cycle pulse; 1 in the cycle after `count` wrapped (or saturated, see Optional Feature).

Behaviour:
- Reset, sampled at the rising edge:
  - `count` ← `RESET_VALUE`; `wrap` ← 0.
  - `rst` overrides `load` and `en`.
- Priority per edge when not in reset: `load` > `en` > hold.
- Load (`load`=1):
  - `count` ← `load_value` next edge; `wrap` ← 0.
  - `en` and `direction` are ignored that cycle.
- Count (`en`=1, `load`=0):
  - `direction`=1: `count` ← `count`+1 modulo 2^`DATA_WIDTH`.
  - `direction`=0: `count` ← `count`−1 modulo 2^`DATA_WIDTH`.
- Hold (`en`=0, `load`=0): `count` holds; `wrap` ← 0.
- Latency: one cycle from sampled control to new `count`. No handshake.
- Wrap-around:
  - Up from all-ones gives 0 with `wrap`=1 the next cycle.
  - Down from 0 gives all-ones with `wrap`=1 the next cycle.
  - `wrap` is asserted in the same cycle the wrapped `count` value is visible.
- `tc` follows `direction` combinationally, even while `en`=0.
- `direction` may change every cycle. The new direction applies on the next enabled edge; there is no pipeline or turnaround delay.
- Reset asserted mid-count: the count is lost; the next cycle shows `RESET_VALUE`.
- An X or Z on `direction` while `en`=1 is illegal. The bench must hold `en`=0 until `direction` is driven.

Optional Feature:
- Macro: `COUNTER_SATURATE_EN`.
- Defined: counter saturates instead of wrapping.
  - Up at all-ones stays all-ones; down at 0 stays 0.
  - `wrap` pulses 1 for each enabled step attempted while at the limit (overflow/underflow indication).
  - Load and reset behaviour are unchanged.
- Undefined: modular wrap-around as in Behaviour.

Decomposition:
- Shared package `counter_pkg`:
  - direction encoding constants `DIR_UP`=1'b1, `DIR_DOWN`=1'b0;
  - helper function returning the all-ones value for a given width.
- One sub-module is natural: `counter_next`, purely combinational.
  - Computes next count, `tc` and wrap/saturate detection from `count`, `direction`, `en`, `load`, `load_value`.
  - Top level holds only the `count`/`wrap` registers and reset.

Test Plan (`DATA_WIDTH`=4, `RESET_VALUE`=0, clock period 4 ns):
- Reset, then up count:
  - Hold `rst`=1 for 25 cycles → `count`=0, `wrap`=0 throughout.
  - Release `rst`, `en`=1, `direction`=1 → `count` 1,2,3… one step per cycle.
- Up wrap:
  - From 15 with `direction`=1, `en`=1 → next `count`=0, `wrap`=1 for exactly one cycle.
  - `tc`=1 while `count`=15.
- Down count and wrap:
  - Load 2, `direction`=0, `en`=1 → `count` 1, 0, 15; `wrap`=1 in the cycle `count`=15.
  - `tc`=1 while `count`=0.
- Direction toggle:
  - Up 3 steps from 0, switch `direction` to 0 for 3 steps → `count` 1,2,3,2,1,0 with no skipped or held cycle.
- Load and enable priority:
  - `load`=1, `load_value`=9, `en`=1, `direction`=1 → `count`=9 (not 10).
  - `en`=0 for 5 cycles → `count` stays 9.
  - `rst`=1 together with `load`=1 → `count`=0.
- Saturate build (`COUNTER_SATURATE_EN` defined):
  - At 15 counting up 3 cycles → `count` stays 15, `wrap`=1 each cycle.
  - At 0 counting down → `count` stays 0, `wrap`=1.
